clb_cfg_loader: RTL and testbench

//  Serial configuration loader directly upstream of the CLB array.
//  - Receives a framed bitstream on DIN and shifts it into a shadow register.
//  - Validates the frame, then commits it atomically to the parallel CFG bus.
//  - CFG drives each CLB's LUT memory, mux selects, DQ muxes and flop/latch bit,

---
 rtl/clb_cfg_pkg.sv | 38 +++
 rtl/clb_cfg_crc8.sv | 33 +++
 rtl/clb_cfg_loader.sv | 182 ++++++++++++++++++
 tb/tb_clb_cfg_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// rtl/clb_cfg_pkg.sv - CLB config field map, loader states and frame constants
// Shared with the CLB so it can slice the CFG bus.
package clb_cfg_pkg;

  localparam int CFG_W = 37;

  // Per-CLB field map, MSB first: mem16 | comboption2 | mux sel 5x2 | o2m 6 | DQmux 2 | floporlatch 1
  localparam int FL_BIT     = 0;
  localparam int DQ_LSB     = 1;
  localparam int O2M_LSB    = 3;
  localparam int MUXSEL_LSB = 9;
  localparam int COMB_LSB   = 19;
  localparam int MEM_LSB    = 21;

  localparam int DQ_W     = 2;
  localparam int O2M_W    = 6;
  localparam int MUXSEL_W = 10;
  localparam int COMB_W   = 2;
  localparam int MEM_W    = 16;

  localparam logic [7:0] PRE      = 8'hF2;
  localparam logic [7:0] CRC_POLY = 8'h07;

  localparam logic [2:0] S_HUNT   = 3'd0;
  localparam logic [2:0] S_LEN    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/clb_cfg_crc8.sv
// rtl/clb_cfg_crc8.sv - serial CRC-8, MSB first, init 0x00
// Clear wins over enable so a new frame can restart on the same edge.
module clb_cfg_crc8 import clb_cfg_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/clb_cfg_loader.sv
// rtl/clb_cfg_loader.sv - serial framed config loader feeding the CLB array
// Optional CRC-8 frame check is built in when CFG_CRC_EN is defined.
module clb_cfg_loader import clb_cfg_pkg::*; #(
  parameter int NUM_CLB = 4
) (
  input  logic                     K,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     DIN,
  output logic [NUM_CLB*CFG_W-1:0] CFG,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);

  localparam int PAY_W = NUM_CLB * CFG_W;
  localparam int CNT_W = $clog2(PAY_W + 1);
  localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_PAY_LAST  = CNT_W'(PAY_W - 1);
  localparam logic [7:0]       LEN_OK        = 8'(NUM_CLB);

  logic [2:0]       state_q, state_d;
  logic [7:0]       window_q, window_d;
  logic [7:0]       byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAY_W-1:0] shadow_q, shadow_d;
  logic [PAY_W-1:0] cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             commit_q, commit_d;

  logic [7:0] window_nx;
  logic [7:0] byte_nx;
  logic       hunting;
  logic       pre_hit;

  assign window_nx = {window_q[6:0], DIN};
  assign byte_nx   = {byte_q[6:0], DIN};
  assign hunting   = (state_q == S_HUNT) || (state_q == S_DONE) || (state_q == S_ERR);
  assign pre_hit   = CE && hunting && (window_nx == PRE);

`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic       crc_en;

  assign crc_en = CE && ((state_q == S_LEN) || (state_q == S_LOAD));

  clb_cfg_crc8 u_crc (
    .clk   (K),
    .rst   (RST),
    .clear (pre_hit),
    .en    (crc_en),
    .din   (DIN),
    .crc   (crc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    byte_d   = byte_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = done_q;
    err_d    = err_q;
    commit_d = 1'b0;

    // DONE trails the CFG update by one cycle so CFG is stable when DONE rises
    if (commit_q) begin
      done_d = 1'b1;
    end

    case (state_q)
      S_HUNT, S_DONE, S_ERR: begin
        if (CE) begin
          window_d = window_nx;
          if (pre_hit) begin
            // Window restarts empty so stale frame bits can never fake a preamble later
            window_d = 8'h00;
            byte_d   = 8'h00;
            cnt_d    = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            state_d  = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (CE) begin
          byte_d = byte_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_BYTE_LAST) begin
            cnt_d = '0;
            if (byte_nx != LEN_OK) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        if (CE) begin
          shadow_d = {shadow_q[PAY_W-2:0], DIN};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_PAY_LAST) begin
            cnt_d = '0;
`ifdef CFG_CRC_EN
            byte_d  = 8'h00;
            state_d = S_CHECK;
`else
            state_d = S_COMMIT;
`endif
          end
        end
      end

`ifdef CFG_CRC_EN
      S_CHECK: begin
        if (CE) begin
          byte_d = byte_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_BYTE_LAST) begin
            cnt_d = '0;
            if (byte_nx == crc) begin
              state_d = S_COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
        end
      end
`endif

      S_COMMIT: begin
        cfg_d    = shadow_q;
        commit_d = 1'b1;
        state_d  = S_DONE;
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge K) begin
    if (RST) begin
      state_q  <= S_HUNT;
      window_q <= 8'h00;
      byte_q   <= 8'h00;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      byte_q   <= byte_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
      commit_q <= commit_d;
    end
  end

  assign CFG  = cfg_q;
  assign BUSY = (state_q == S_LEN) || (state_q == S_LOAD) ||
                (state_q == S_CHECK) || (state_q == S_COMMIT);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb/tb_clb_cfg_loader.sv - directed self-checking bench for clb_cfg_loader
// Covers both builds; the CRC byte is sent only when CFG_CRC_EN is defined.
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int NUM_CLB = 4;
  localparam int PAY_W   = NUM_CLB * CFG_W;

  logic             K = 1'b0;
  logic             RST;
  logic             CE;
  logic             DIN;
  logic [PAY_W-1:0] CFG;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  int total = 0;
  int bad   = 0;

  logic [7:0]       pre_v;
  logic [PAY_W-1:0] pat_a;
  logic [PAY_W-1:0] pat_b;
  logic [PAY_W-1:0] zero_v;

  clb_cfg_loader #(.NUM_CLB(NUM_CLB)) dut (
    .K    (K),
    .RST  (RST),
    .CE   (CE),
    .DIN  (DIN),
    .CFG  (CFG),
    .BUSY (BUSY),
    .DONE (DONE),
    .ERR  (ERR)
  );

  always #5 K = ~K;

  task automatic check(input string tag, input logic [PAY_W-1:0] obs, input logic [PAY_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] len, input logic [PAY_W-1:0] pay);
    logic [7:0]       c;
    logic [PAY_W+7:0] msg;
    c   = 8'h00;
    msg = {len, pay};
    for (int i = PAY_W + 7; i >= 0; i--) begin
      if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else               c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic bit_in(input logic b);
    CE  = 1'b1;
    DIN = b;
    @(negedge K);
  endtask

  task automatic idle(input int n);
    CE  = 1'b0;
    DIN = 1'b0;
    repeat (n) @(negedge K);
  endtask

  task automatic bits_in(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) bit_in(v[i]);
  endtask

  task automatic payload_in(input logic [PAY_W-1:0] v, input int hi, input int lo, input bit toggle);
    for (int i = hi; i >= lo; i--) begin
      bit_in(v[i]);
      if (toggle) idle(1);
    end
  endtask

  task automatic crc_in(input logic [PAY_W-1:0] pay, input bit flip);
`ifdef CFG_CRC_EN
    bits_in(crc_model(8'd4, pay) ^ {7'd0, flip}, 7, 0);
`endif
  endtask

  task automatic commit_checks(input string tag, input logic [PAY_W-1:0] old_cfg, input logic [PAY_W-1:0] new_cfg);
    check({tag, "_busy_in_commit"}, BUSY, 1);
    check({tag, "_cfg_before_commit"}, CFG, old_cfg);
    check({tag, "_done_before_commit"}, DONE, 0);
    idle(1);
    check({tag, "_cfg_committed"}, CFG, new_cfg);
    check({tag, "_busy_after_commit"}, BUSY, 0);
    check({tag, "_done_lags_cfg"}, DONE, 0);
    idle(1);
    check({tag, "_done"}, DONE, 1);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_cfg_held"}, CFG, new_cfg);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    CE  = 1'b0;
    DIN = 1'b0;
    @(negedge K);
    RST = 1'b0;
  endtask

  initial begin
    pre_v  = 8'hF2;
    pat_a  = {4{37'h0_0116_0000}};
    pat_b  = {37'h1_E5F2_F2A5, 37'h0_2345_6789, 37'h1_ABCD_EF01, 37'h0_F2F2_1F2F};
    zero_v = '0;
    RST = 1'b1;
    CE  = 1'b0;
    DIN = 1'b0;
    @(negedge K);
    @(negedge K);
    RST = 1'b0;

    check("rst_cfg", CFG, zero_v);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);

    // bad length: len=3 rejected after its 8th bit
    bits_in(pre_v, 7, 0);
    check("t2_busy_after_pre", BUSY, 1);
    bits_in(8'd3, 7, 1);
    check("t2_no_err_before_8th", ERR, 0);
    bits_in(8'd3, 0, 0);
    check("t2_err", ERR, 1);
    check("t2_busy_drops", BUSY, 0);
    check("t2_cfg_zero", CFG, zero_v);
    check("t2_done", DONE, 0);

    // valid frame A, entered from ERR
    bits_in(pre_v, 7, 1);
    check("t1_err_held_in_pre", ERR, 1);
    bits_in(pre_v, 0, 0);
    check("t1_err_clear_on_len", ERR, 0);
    check("t1_busy_len", BUSY, 1);
    bits_in(8'd4, 7, 0);
    payload_in(pat_a, PAY_W - 1, 74, 1'b0);
    check("t1_busy_mid_load", BUSY, 1);
    check("t1_cfg_mid_load", CFG, zero_v);
    payload_in(pat_a, 73, 0, 1'b0);
    crc_in(pat_a, 1'b0);
    commit_checks("t1", zero_v, pat_a);

    // second frame after DONE, payload carries F2 patterns
    bits_in(pre_v, 7, 1);
    check("t6_done_held_in_pre", DONE, 1);
    bits_in(pre_v, 0, 0);
    check("t6_done_clear_on_len", DONE, 0);
    bits_in(8'd4, 7, 0);
    payload_in(pat_b, PAY_W - 1, 0, 1'b0);
    crc_in(pat_b, 1'b0);
    commit_checks("t6", pat_a, pat_b);

    // frame A again: bad CRC rejected, or plain commit without CRC
    bits_in(pre_v, 7, 0);
    bits_in(8'd4, 7, 0);
    payload_in(pat_a, PAY_W - 1, 0, 1'b0);
`ifdef CFG_CRC_EN
    crc_in(pat_a, 1'b1);
    check("t3_err", ERR, 1);
    check("t3_busy", BUSY, 0);
    check("t3_done", DONE, 0);
    check("t3_cfg_kept", CFG, pat_b);
    idle(2);
    check("t3_cfg_still_kept", CFG, pat_b);
`else
    commit_checks("t3", pat_b, pat_a);
`endif

    // reset in the middle of the payload
    bits_in(pre_v, 7, 0);
    bits_in(8'd4, 7, 0);
    payload_in(pat_a, PAY_W - 1, PAY_W - 70, 1'b0);
    check("t5_busy_before_rst", BUSY, 1);
    pulse_reset();
    check("t5_cfg_zero", CFG, zero_v);
    check("t5_busy", BUSY, 0);
    check("t5_done", DONE, 0);
    check("t5_err", ERR, 0);

    // CE toggling during load, from a clean HUNT
    bits_in(pre_v, 7, 0);
    bits_in(8'd4, 7, 0);
    payload_in(pat_a, PAY_W - 1, 48, 1'b1);
    check("t4_busy_mid", BUSY, 1);
    check("t4_cfg_mid", CFG, zero_v);
    check("t4_done_mid", DONE, 0);
    idle(3);
    check("t4_busy_ce_low", BUSY, 1);
    payload_in(pat_a, 47, 0, 1'b1);
    crc_in(pat_a, 1'b0);
`ifndef CFG_CRC_EN
    bit_in(1'b0);
`endif
    // without CRC the trailing toggle idle already spent the commit cycle
`ifdef CFG_CRC_EN
    commit_checks("t4", zero_v, pat_a);
`else
    check("t4_cfg_committed", CFG, pat_a);
    check("t4_done", DONE, 1);
    check("t4_err", ERR, 0);
    check("t4_busy", BUSY, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
